// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input conditioning stage:
// PS/2 scancodes, joystick bit positions and the coin FSM state type.
package arcade_input_pkg;

  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_START1 = 8'h05;
  localparam logic [7:0] SC_START2 = 8'h06;
  localparam logic [7:0] SC_COIN   = 8'h2E;

  localparam int unsigned JOY_RIGHT  = 32'd0;
  localparam int unsigned JOY_LEFT   = 32'd1;
  localparam int unsigned JOY_DOWN   = 32'd2;
  localparam int unsigned JOY_UP     = 32'd3;
  localparam int unsigned JOY_FIRE   = 32'd4;
  localparam int unsigned JOY_START1 = 32'd5;
  localparam int unsigned JOY_START2 = 32'd6;
  localparam int unsigned JOY_COIN   = 32'd7;
  localparam int unsigned NUM_CTRL   = 32'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  // Counter must hold max(pulse, gap) - 1 and never collapse to zero bits.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    if ($clog2(m) < 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(m);
    end
  endfunction

endpackage

// File: rtl/ps2_key_latch.sv
// Turns PS/2 toggle events into held-key levels, laid out like the joystick
// bits so the top can OR them directly.
module ps2_key_latch
  import arcade_input_pkg::*;
(
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [10:0]         ps2_key,
  output logic [NUM_CTRL-1:0] keys
);

  logic                tog_q_r;
  logic                armed_r;
  logic [NUM_CTRL-1:0] keys_r;
  logic                event_s;
  logic [NUM_CTRL-1:0] keys_next_s;

  // Scancode decode: one event updates at most one held-key register.
  always_comb begin
    keys_next_s = keys_r;
    event_s     = armed_r & (ps2_key[10] != tog_q_r);
    if (event_s) begin
      case (ps2_key[7:0])
        SC_UP:     keys_next_s[JOY_UP]    = ps2_key[9];
        SC_DOWN:   keys_next_s[JOY_DOWN]  = ps2_key[9];
        SC_LEFT:   keys_next_s[JOY_LEFT]  = ps2_key[9];
        SC_RIGHT:  keys_next_s[JOY_RIGHT] = ps2_key[9];
        SC_CTRL:   keys_next_s[JOY_FIRE]  = ps2_key[9];
        SC_SPACE:  keys_next_s[JOY_FIRE]   = ps2_key[8] ? keys_r[JOY_FIRE]   : ps2_key[9];
        SC_START1: keys_next_s[JOY_START1] = ps2_key[8] ? keys_r[JOY_START1] : ps2_key[9];
        SC_START2: keys_next_s[JOY_START2] = ps2_key[8] ? keys_r[JOY_START2] : ps2_key[9];
        SC_COIN:   keys_next_s[JOY_COIN]   = ps2_key[8] ? keys_r[JOY_COIN]   : ps2_key[9];
        default:   keys_next_s = keys_r;
      endcase
    end else begin
      keys_next_s = keys_r;
    end
  end

  // The unarmed first cycle only samples the toggle, so a stale level is not an event.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q_r <= 1'b0;
      armed_r <= 1'b0;
      keys_r  <= {NUM_CTRL{1'b0}};
    end else begin
      tog_q_r <= ps2_key[10];
      armed_r <= 1'b1;
      keys_r  <= keys_next_s;
    end
  end

  assign keys = keys_r;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Merges PS/2 keys with both joysticks, applies the Horz remap and produces
// a timed coin pulse with lockout; all player controls leave registered.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int unsigned COIN_PULSE_CYC = 32'd1_200_000,
  parameter int unsigned COIN_GAP_CYC   = 32'd1_200_000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic        fire,
  output logic        start1,
  output logic        start2,
  output logic        coin
);

  localparam int unsigned CNT_W = cnt_width(COIN_PULSE_CYC, COIN_GAP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYC - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP_CYC - 32'd1);

  logic [NUM_CTRL-1:0] keys_s;
  logic [NUM_CTRL-1:0] raw_s;
  logic                unused_s;
  logic                up_s, down_s, left_s, right_s;
  logic                coin_req_s, rise_s;
  logic                req_q_r, req_d_r;
  coin_state_t         state_r, state_next_s;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic                up_r, down_r, left_r, right_r, fire_r;
  logic                start1_r, start2_r, coin_r;

  ps2_key_latch u_key_latch (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_key (ps2_key),
    .keys    (keys_s)
  );

  assign raw_s      = keys_s | joystick_0[7:0] | joystick_1[7:0];
  assign unused_s   = ^{joystick_0[15:8], joystick_1[15:8]};
  assign coin_req_s = raw_s[JOY_START1] | raw_s[JOY_START2] | raw_s[JOY_COIN];
  assign rise_s     = req_q_r & ~req_d_r;

  // Horz cabinet remap of the four directions.
  always_comb begin
    if (rotate) begin
      up_s    = raw_s[JOY_LEFT];
      down_s  = raw_s[JOY_RIGHT];
      left_s  = raw_s[JOY_DOWN];
      right_s = raw_s[JOY_UP];
    end else begin
      up_s    = raw_s[JOY_UP];
      down_s  = raw_s[JOY_DOWN];
      left_s  = raw_s[JOY_LEFT];
      right_s = raw_s[JOY_RIGHT];
    end
  end

  // Coin FSM next state; edges outside IDLE are simply not looked at.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_next_s = PULSE;
          cnt_next_s   = PULSE_LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      PULSE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_next_s = GAP;
          cnt_next_s   = GAP_LOAD;
        end else begin
          cnt_next_s = cnt_r - CNT_W'(1'b1);
        end
      end
      GAP: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_next_s = IDLE;
        end else begin
          cnt_next_s = cnt_r - CNT_W'(1'b1);
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Request history resets high so a start held through reset needs a fresh press.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      req_q_r <= 1'b1;
      req_d_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      req_q_r <= coin_req_s;
      req_d_r <= req_q_r;
    end
  end

  // Output registers; starts are held off while the credit pulse is live.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      up_r     <= 1'b0;
      down_r   <= 1'b0;
      left_r   <= 1'b0;
      right_r  <= 1'b0;
      fire_r   <= 1'b0;
      start1_r <= 1'b0;
      start2_r <= 1'b0;
      coin_r   <= 1'b0;
    end else begin
      up_r     <= up_s;
      down_r   <= down_s;
      left_r   <= left_s;
      right_r  <= right_s;
      fire_r   <= raw_s[JOY_FIRE];
      start1_r <= raw_s[JOY_START1] & (state_r != PULSE);
      start2_r <= raw_s[JOY_START2] & (state_r != PULSE);
      coin_r   <= (state_r == PULSE);
    end
  end

  assign up     = up_r;
  assign down   = down_r;
  assign left   = left_r;
  assign right  = right_r;
  assign fire   = fire_r;
  assign start1 = start1_r;
  assign start2 = start2_r;
  assign coin   = coin_r;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl with a 4-cycle coin pulse and 3-cycle gap.
module tb_arcade_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = 11'd0;
  logic [15:0] joystick_0 = 16'd0;
  logic [15:0] joystick_1 = 16'd0;
  logic        rotate = 1'b0;
  logic        up, down, left, right, fire, start1, start2, coin;
  logic [7:0]  outs;
  logic [7:0]  exp_v;
  logic        exp_coin;
  int          checks = 0;
  int          failures = 0;

  arcade_input_ctrl #(.COIN_PULSE_CYC(4), .COIN_GAP_CYC(3)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1), .rotate(rotate),
    .up(up), .down(down), .left(left), .right(right), .fire(fire),
    .start1(start1), .start2(start2), .coin(coin)
  );

  // Packed as {up,down,left,right,fire,start1,start2,coin}.
  assign outs = {up, down, left, right, fire, start1, start2, coin};

  always #5 clk_sys = ~clk_sys;

  task automatic step;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ps2_event(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic test_reset;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    reset_n = 1'b0;
    step();
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL reset_outs got=%b want=%b", outs, 8'h00);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (outs !== 8'h00) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got=%b want=%b", i, outs, 8'h00);
      end
    end
  endtask

  task automatic test_ps2_dir(input logic rot, input logic [7:0] exp_on);
    rotate = rot;
    ps2_event(1'b1, 1'b1, 8'h75);
    step();
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL ps2_latency rot=%0b got=%b want=%b", rot, outs, 8'h00);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (outs !== exp_on) begin
        failures++;
        $display("FAIL ps2_held rot=%0b cyc=%0d got=%b want=%b", rot, i, outs, exp_on);
      end
      if (i == 8) ps2_event(1'b0, 1'b1, 8'h75);
    end
    step();
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL ps2_release rot=%0b got=%b want=%b", rot, outs, 8'h00);
    end
    rotate = 1'b0;
  endtask

  task automatic test_start_coin;
    joystick_0[5] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      exp_coin = (j >= 2 && j <= 5);
      exp_v = {5'b00000, ~exp_coin, 1'b0, exp_coin};
      checks++;
      if (outs !== exp_v) begin
        failures++;
        $display("FAIL start_coin cyc=%0d got=%b want=%b", j, outs, exp_v);
      end
    end
    joystick_0[5] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      checks++;
      if (outs !== 8'h00) begin
        failures++;
        $display("FAIL start_release cyc=%0d got=%b want=%b", j, outs, 8'h00);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int j = 0; j < 19; j++) begin
      joystick_1[7] = (j == 0 || j == 3 || j == 6 || j == 9);
      step();
      exp_coin = (j >= 2 && j <= 5) || (j >= 11 && j <= 14);
      exp_v = {7'b0000000, exp_coin};
      checks++;
      if (outs !== exp_v) begin
        failures++;
        $display("FAIL coin_lockout cyc=%0d got=%b want=%b", j, outs, exp_v);
      end
    end
    joystick_1[7] = 1'b0;
  endtask

  task automatic test_fire_keys;
    ps2_event(1'b1, 1'b1, 8'h29);
    step(); step();
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL space_ext got=%b want=%b", outs, 8'h00);
    end
    ps2_event(1'b1, 1'b1, 8'h14);
    step();
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL ctrl_latency got=%b want=%b", outs, 8'h00);
    end
    step();
    checks++;
    if (outs !== 8'b0000_1000) begin
      failures++;
      $display("FAIL ctrl_ext_fire got=%b want=%b", outs, 8'b0000_1000);
    end
    ps2_event(1'b1, 1'b0, 8'h1C);
    step(); step();
    checks++;
    if (outs !== 8'b0000_1000) begin
      failures++;
      $display("FAIL unknown_code got=%b want=%b", outs, 8'b0000_1000);
    end
    ps2_event(1'b0, 1'b0, 8'h29);
    step(); step();
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL space_release got=%b want=%b", outs, 8'h00);
    end
  endtask

  task automatic test_reset_in_pulse;
    joystick_0[5] = 1'b1;
    step(); step(); step();
    checks++;
    if (coin !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_pulse got=%b want=%b", coin, 1'b1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL async_reset got=%b want=%b", outs, 8'h00);
    end
    step(); step();
    reset_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      checks++;
      if (outs !== 8'b0000_0100) begin
        failures++;
        $display("FAIL held_start_no_pulse cyc=%0d got=%b want=%b", j, outs, 8'b0000_0100);
      end
    end
    joystick_0[5] = 1'b0;
    step();
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL start_drop got=%b want=%b", outs, 8'h00);
    end
    joystick_0[5] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      exp_coin = (j >= 2 && j <= 5);
      exp_v = {5'b00000, ~exp_coin, 1'b0, exp_coin};
      checks++;
      if (outs !== exp_v) begin
        failures++;
        $display("FAIL repress_pulse cyc=%0d got=%b want=%b", j, outs, exp_v);
      end
    end
    joystick_0[5] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ps2_dir(1'b0, 8'b1000_0000);
    test_ps2_dir(1'b1, 8'b0001_0000);
    test_start_coin();
    test_back_to_back();
    test_fire_keys();
    test_reset_in_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
